// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter that shares one memory port between the I-cache and D-cache.
// One transaction is outstanding at a time. A per-transaction timeout completes with err=1.
//
// state | meaning
// IDLE  | sample i_req/d_req, pick a winner, launch the memory request
// BUSY  | mem_* held stable, waiting for mem_ack or the timeout
// RESP  | one-cycle ack pulse to the winner, then back to IDLE
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_ack,
    output logic                    i_err,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_ack,
    output logic                    d_err,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            last_d;
    logic            owner_d;

    logic            any_req;
    logic            grant_d;
    logic            done;
    logic            rsp_err;
    logic [DATA_WIDTH-1:0] rsp_data;

    // On contention the side that did not win last time gets the port.
    always_comb begin
        any_req  = i_req | d_req;
        grant_d  = d_req & (~i_req | ~last_d);
        done     = mem_ack | (TIMEOUT_EN & (cnt == CNT_LAST));
        rsp_err  = ~mem_ack;
        rsp_data = mem_ack ? mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            last_d    <= 1'b1;
            owner_d   <= 1'b0;
            i_rdata   <= '0;
            i_ack     <= 1'b0;
            i_err     <= 1'b0;
            d_rdata   <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state   <= BUSY;
                        cnt     <= '0;
                        owner_d <= grant_d;
                        last_d  <= grant_d;
                        mem_req <= 1'b1;
                        if (grant_d) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_wstrb <= d_we ? d_wstrb : {SW{1'b0}};
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            mem_wstrb <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (done) begin
                        state     <= RESP;
                        cnt       <= '0;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        if (owner_d) begin
                            d_ack   <= 1'b1;
                            d_rdata <= rsp_data;
                            d_err   <= rsp_err;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= rsp_data;
                            i_err   <= rsp_err;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios with literal expectations, then a
// randomized run checked every cycle against a transaction-level model.
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int T  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req, d_req, d_we, mem_ack;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [SW-1:0] d_wstrb;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic          i_ack, i_err, d_ack, d_err, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_wstrb;

    int vectors = 0;
    int miscompares = 0;

    cache_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_i_rdata"}, i_rdata, 0);
        chk({tag, "_i_ack"}, i_ack, 0);
        chk({tag, "_i_err"}, i_err, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
        chk({tag, "_d_ack"}, d_ack, 0);
        chk({tag, "_d_err"}, d_err, 0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
    endtask

    // Transaction-level model: a grant at edge g occupies the port for b cycles
    // (b = ack latency, or T on timeout), acks in the cycle after, and the arbiter
    // samples requests again one cycle later.
    task automatic run_random(input int ncycles);
        int            k = 0;
        int            g = 0, b = 0, lat = 0, free_edge = 0;
        bit            active = 0, own_d = 0, last_d = 1, to = 0;
        bit            in_busy = 0, i_seen = 0, d_seen = 0, ack_now;
        logic [DW-1:0] txn_rdata = '0;
        logic [AW-1:0] e_addr = '0;
        logic [DW-1:0] e_wdata = '0;
        logic [SW-1:0] e_wstrb = '0;
        logic          e_we = 0;
        logic [DW-1:0] e_i_rdata = '0, e_d_rdata = '0;
        logic          e_i_err = 0, e_d_err = 0;
        repeat (ncycles) begin
            if (i_seen) begin
                if ($urandom_range(0, 1) == 1) begin i_req = 1; i_addr = $urandom; end
                else i_req = 0;
            end else if (!i_req) begin
                if ($urandom_range(0, 2) == 0) begin i_req = 1; i_addr = $urandom; end
            end else if (in_busy && !own_d && $urandom_range(0, 9) == 0) begin
                i_req = 0; i_addr = $urandom;
            end
            if (d_seen) begin
                if ($urandom_range(0, 1) == 1) begin
                    d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
                    d_wdata = $urandom; d_wstrb = SW'($urandom);
                end else d_req = 0;
            end else if (!d_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
                    d_wdata = $urandom; d_wstrb = SW'($urandom);
                end
            end else if (in_busy && own_d && $urandom_range(0, 9) == 0) begin
                d_req = 0; d_addr = $urandom; d_wdata = $urandom;
            end
            if (active && !to && k == g + lat - 1) begin
                mem_ack = 1; mem_rdata = txn_rdata;
            end else begin
                mem_ack = !in_busy && ($urandom_range(0, 7) == 0);
                mem_rdata = $urandom;
            end
            if (!active && k + 1 >= free_edge && (i_req || d_req)) begin
                if (i_req && d_req) own_d = !last_d;
                else own_d = d_req;
                last_d = own_d;
                g = k + 1;
                lat = $urandom_range(1, T + 2);
                to = (lat > T);
                b = to ? T : lat;
                txn_rdata = $urandom;
                if (own_d) begin
                    e_addr = d_addr; e_we = d_we; e_wdata = d_wdata;
                    e_wstrb = d_we ? d_wstrb : '0;
                end else begin
                    e_addr = i_addr; e_we = 0; e_wdata = '0; e_wstrb = '0;
                end
                active = 1;
            end

            tick();
            k++;

            in_busy = active && k >= g && k <= g + b - 1;
            ack_now = active && k == g + b;
            i_seen = ack_now && !own_d;
            d_seen = ack_now && own_d;
            if (i_seen) begin e_i_rdata = to ? '0 : txn_rdata; e_i_err = to; end
            if (d_seen) begin e_d_rdata = to ? '0 : txn_rdata; e_d_err = to; end
            chk("rnd_mem_req", mem_req, in_busy);
            chk("rnd_i_ack", i_ack, i_seen);
            chk("rnd_d_ack", d_ack, d_seen);
            chk("rnd_i_rdata", i_rdata, e_i_rdata);
            chk("rnd_i_err", i_err, e_i_err);
            chk("rnd_d_rdata", d_rdata, e_d_rdata);
            chk("rnd_d_err", d_err, e_d_err);
            if (in_busy) begin
                chk("rnd_mem_addr", mem_addr, e_addr);
                chk("rnd_mem_we", mem_we, e_we);
                chk("rnd_mem_wstrb", mem_wstrb, e_wstrb);
                if (e_we) chk("rnd_mem_wdata", mem_wdata, e_wdata);
            end
            if (ack_now) begin
                active = 0;
                free_edge = k + 2;
            end
        end
    endtask

    initial begin
        int hi, n;
        int order[$];
        int exp_order[4] = '{0, 1, 0, 1};

        idle_inputs();
        rst_n = 0;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1;

        // Minimum-latency I read
        i_req = 1; i_addr = 32'h100;
        tick();
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_wstrb", mem_wstrb, 0);
        chk("t1_i_ack_early", i_ack, 0);
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("t1_mem_req_drop", mem_req, 0);
        chk("t1_i_ack", i_ack, 1);
        chk("t1_i_rdata", i_rdata, 32'hDEADBEEF);
        chk("t1_i_err", i_err, 0);
        chk("t1_d_ack", d_ack, 0);
        mem_ack = 0; mem_rdata = '0; i_req = 0;
        tick();
        chk("t1_i_ack_pulse", i_ack, 0);
        chk("t1_i_rdata_hold", i_rdata, 32'hDEADBEEF);

        // D write, ack in third BUSY cycle
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t3_mem_req", mem_req, 1);
            chk("t3_mem_we", mem_we, 1);
            chk("t3_mem_wstrb", mem_wstrb, 4'b0011);
            chk("t3_mem_addr", mem_addr, 32'h40);
            chk("t3_mem_wdata", mem_wdata, 32'h12345678);
            chk("t3_d_ack_early", d_ack, 0);
            if (c == 2) begin mem_ack = 1; mem_rdata = 32'hA5A5A5A5; end
        end
        tick();
        chk("t3_d_ack", d_ack, 1);
        chk("t3_d_err", d_err, 0);
        chk("t3_d_rdata", d_rdata, 32'hA5A5A5A5);
        chk("t3_mem_req_drop", mem_req, 0);
        mem_ack = 0; d_req = 0; d_we = 0; d_wstrb = '0;
        tick();
        chk("t3_d_ack_pulse", d_ack, 0);

        // D read that never gets mem_ack
        d_req = 1; d_addr = 32'h80;
        hi = 0;
        for (n = 0; n < 20 && !d_ack; n++) begin
            tick();
            if (mem_req) hi++;
        end
        chk("t4_ack_seen", d_ack, 1);
        chk("t4_mem_req_cycles", hi, T);
        chk("t4_d_err", d_err, 1);
        chk("t4_d_rdata", d_rdata, 0);
        d_req = 0;
        tick();
        tick();
        mem_ack = 1; mem_rdata = 32'hFFFF0000;
        tick();
        mem_ack = 0;
        chk("t4_stray_d_ack", d_ack, 0);
        chk("t4_stray_i_ack", i_ack, 0);
        chk("t4_stray_mem_req", mem_req, 0);
        chk("t4_stray_d_err", d_err, 1);
        chk("t4_stray_d_rdata", d_rdata, 0);
        d_req = 1; d_addr = 32'h200;
        tick();
        chk("t4_after_mem_req", mem_req, 1);
        chk("t4_after_mem_addr", mem_addr, 32'h200);
        mem_ack = 1; mem_rdata = 32'h1111;
        tick();
        chk("t4_after_d_ack", d_ack, 1);
        chk("t4_after_d_rdata", d_rdata, 32'h1111);
        mem_ack = 0; d_req = 0;
        tick();

        // Contended stream
        i_req = 1; i_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h400;
        for (n = 0; n < 60 && order.size() < 4; n++) begin
            tick();
            chk("t2_no_overlap", i_ack & d_ack, 0);
            if (i_ack) order.push_back(0);
            if (d_ack) order.push_back(1);
            if (mem_req && !mem_ack) begin mem_ack = 1; mem_rdata = 32'h5000 + 32'(n); end
            else mem_ack = 0;
        end
        chk("t2_ack_count", order.size(), 4);
        for (int j = 0; j < 4 && j < order.size(); j++) chk("t2_grant_order", order[j], exp_order[j]);
        i_req = 0; d_req = 0; mem_ack = 0;
        tick();
        tick();

        // Async reset during a D read
        d_req = 1; d_addr = 32'h500;
        tick();
        chk("t5_mem_req", mem_req, 1);
        #2;
        rst_n = 0;
        #1;
        check_all_zero("t5_async");
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("t5_rst_d_ack", d_ack, 0);
            chk("t5_rst_mem_req", mem_req, 0);
        end
        @(negedge clk);
        rst_n = 1;
        i_req = 1; i_addr = 32'h600; d_req = 1; d_addr = 32'h700;
        tick();
        chk("t5_first_mem_req", mem_req, 1);
        chk("t5_first_grant_addr", mem_addr, 32'h600);
        mem_ack = 1; mem_rdata = 32'h6060;
        tick();
        chk("t5_i_ack", i_ack, 1);
        chk("t5_d_ack", d_ack, 0);
        idle_inputs();
        tick();

        rst_n = 0;
        tick();
        @(negedge clk);
        rst_n = 1;
        run_random(3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
